// File: rtl/udp_port_demux.sv
// UDP header/payload demultiplexer: routes each frame to the lowest-indexed
// enabled channel whose port_table entry matches the destination port.
module udp_port_demux #(
  parameter int N_PORTS    = 4,
  parameter int DATA_WIDTH = 8,
  localparam int KEEP_WIDTH = DATA_WIDTH / 8,
  localparam int SEL_W      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,

  input  logic [16*N_PORTS-1:0]     port_table,
  input  logic [N_PORTS-1:0]        port_enable,

  input  logic                      s_hdr_valid,
  output logic                      s_hdr_ready,
  input  logic [31:0]               s_ip_source_ip,
  input  logic [15:0]               s_source_port,
  input  logic [15:0]               s_dest_port,
  input  logic [15:0]               s_length,
  input  logic [DATA_WIDTH-1:0]     s_tdata,
  input  logic [KEEP_WIDTH-1:0]     s_tkeep,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  input  logic                      s_tlast,
  input  logic                      s_tuser,

  output logic [N_PORTS-1:0]        m_hdr_valid,
  input  logic [N_PORTS-1:0]        m_hdr_ready,
  output logic [31:0]               m_ip_source_ip,
  output logic [15:0]               m_source_port,
  output logic [15:0]               m_dest_port,
  output logic [15:0]               m_length,
  output logic [DATA_WIDTH-1:0]     m_tdata,
  output logic [KEEP_WIDTH-1:0]     m_tkeep,
  output logic [N_PORTS-1:0]        m_tvalid,
  input  logic [N_PORTS-1:0]        m_tready,
  output logic                      m_tlast,
  output logic                      m_tuser,

  output logic                      busy,
  output logic [31:0]               drop_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    FWD  = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [SEL_W-1:0]  sel_reg, sel_next;
  logic [31:0]       ip_reg, ip_next;
  logic [15:0]       sport_reg, sport_next;
  logic [15:0]       dport_reg, dport_next;
  logic [15:0]       len_reg, len_next;
  logic [31:0]       drop_count_reg, drop_count_next;

  logic [N_PORTS-1:0] hit;
  logic [N_PORTS-1:0] sel_dec;
  logic               match_found;
  logic [SEL_W-1:0]   match_idx;
  logic               hdr_fire;
  logic               sel_hdr_ready;
  logic               sel_tready;

  // Per-channel comparators against the live table; only consulted at the header handshake.
  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_chan
    assign hit[gi]     = port_enable[gi] && (port_table[16*gi +: 16] == s_dest_port);
    assign sel_dec[gi] = (sel_reg == SEL_W'(gi));
  end

  // Lowest index wins: scan downward so the last assignment is the smallest hit.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        match_found = 1'b1;
        match_idx   = SEL_W'(i);
      end
    end
  end

  assign hdr_fire      = s_hdr_valid && (state_reg == IDLE);
  assign sel_hdr_ready = |(m_hdr_ready & sel_dec);
  assign sel_tready    = |(m_tready & sel_dec);

  always_comb begin
    state_next  = state_reg;
    s_hdr_ready = 1'b0;
    s_tready    = 1'b0;
    m_hdr_valid = '0;
    m_tvalid    = '0;
    case (state_reg)
      IDLE: begin
        s_hdr_ready = 1'b1;
        if (s_hdr_valid) begin
          state_next = match_found ? HDR : DROP;
        end
      end
      HDR: begin
        m_hdr_valid = sel_dec;
        if (sel_hdr_ready) begin
          state_next = FWD;
        end
      end
      FWD: begin
        s_tready = sel_tready;
        m_tvalid = sel_dec & {N_PORTS{s_tvalid}};
        if (s_tvalid && sel_tready && s_tlast) begin
          state_next = IDLE;
        end
      end
      DROP: begin
        s_tready = 1'b1;
        if (s_tvalid && s_tlast) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    sel_next        = sel_reg;
    ip_next         = ip_reg;
    sport_next      = sport_reg;
    dport_next      = dport_reg;
    len_next        = len_reg;
    drop_count_next = drop_count_reg;
    if (hdr_fire) begin
      if (match_found) begin
        sel_next   = match_idx;
        ip_next    = s_ip_source_ip;
        sport_next = s_source_port;
        dport_next = s_dest_port;
        len_next   = s_length;
      end else if (drop_count_reg != 32'hFFFF_FFFF) begin
        drop_count_next = drop_count_reg + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      sel_reg        <= '0;
      ip_reg         <= '0;
      sport_reg      <= '0;
      dport_reg      <= '0;
      len_reg        <= '0;
      drop_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      sel_reg        <= sel_next;
      ip_reg         <= ip_next;
      sport_reg      <= sport_next;
      dport_reg      <= dport_next;
      len_reg        <= len_next;
      drop_count_reg <= drop_count_next;
    end
  end

  assign m_ip_source_ip = ip_reg;
  assign m_source_port  = sport_reg;
  assign m_dest_port    = dport_reg;
  assign m_length       = len_reg;

  // Payload sideband is a shared bus; only the per-channel valid selects the consumer.
  assign m_tdata = s_tdata;
  assign m_tkeep = s_tkeep;
  assign m_tlast = s_tlast;
  assign m_tuser = s_tuser;

  assign busy       = (state_reg != IDLE);
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_udp_port_demux.sv
// Randomized bench for udp_port_demux with a frame-level reference model and
// a per-cycle compare process.
module tb_udp_port_demux;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int KW = DW / 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [16*NP-1:0]  port_table = '0;
  logic [NP-1:0]     port_enable = '0;
  logic              s_hdr_valid = 1'b0;
  logic              s_hdr_ready;
  logic [31:0]       s_ip_source_ip = '0;
  logic [15:0]       s_source_port = '0;
  logic [15:0]       s_dest_port = '0;
  logic [15:0]       s_length = '0;
  logic [DW-1:0]     s_tdata = '0;
  logic [KW-1:0]     s_tkeep = '0;
  logic              s_tvalid = 1'b0;
  logic              s_tready;
  logic              s_tlast = 1'b0;
  logic              s_tuser = 1'b0;
  logic [NP-1:0]     m_hdr_valid;
  logic [NP-1:0]     m_hdr_ready = '0;
  logic [31:0]       m_ip_source_ip;
  logic [15:0]       m_source_port;
  logic [15:0]       m_dest_port;
  logic [15:0]       m_length;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tkeep;
  logic [NP-1:0]     m_tvalid;
  logic [NP-1:0]     m_tready = '0;
  logic              m_tlast;
  logic              m_tuser;
  logic              busy;
  logic [31:0]       drop_count;

  udp_port_demux #(.N_PORTS(NP), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n),
    .port_table(port_table), .port_enable(port_enable),
    .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
    .s_ip_source_ip(s_ip_source_ip), .s_source_port(s_source_port),
    .s_dest_port(s_dest_port), .s_length(s_length),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .s_tuser(s_tuser),
    .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready),
    .m_ip_source_ip(m_ip_source_ip), .m_source_port(m_source_port),
    .m_dest_port(m_dest_port), .m_length(m_length),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser),
    .busy(busy), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ch;
    logic [31:0] ip;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [15:0] len;
  } frame_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          u;
  } beat_t;

  frame_t      frames[$];
  beat_t       exp_beats[$];
  bit          hdr_seen = 1'b0;
  logic [31:0] exp_drops = '0;
  bit          hold_hdr1 = 1'b0;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic int model_match(input logic [15:0] d);
    for (int i = 0; i < NP; i++) begin
      if (port_enable[i] && port_table[16*i +: 16] == d) return i;
    end
    return -1;
  endfunction

  function automatic logic [NP-1:0] onehot(input int ch);
    logic [NP-1:0] v;
    v = '0;
    if (ch >= 0) v[ch] = 1'b1;
    return v;
  endfunction

  // Downstream ready generator
  always begin
    @(posedge clk);
    #1;
    m_tready    = NP'($urandom);
    m_hdr_ready = NP'($urandom) & (hold_hdr1 ? 4'b1101 : 4'b1111);
  end

  // Compare process: every cycle the frame-level model says what the DUT must show.
  always @(negedge clk) begin
    bit            idle;
    int            ch;
    logic [NP-1:0] exp_hv;
    logic [NP-1:0] exp_tv;
    logic          exp_str;
    beat_t         bt;
    if (reset_n) begin
      idle = (frames.size() == 0);
      ch   = idle ? -1 : frames[0].ch;
      chk("s_hdr_ready", 64'(s_hdr_ready), 64'(idle));
      chk("busy", 64'(busy), 64'(!idle));
      exp_hv = (!idle && ch >= 0 && !hdr_seen) ? onehot(ch) : '0;
      chk("m_hdr_valid", 64'(m_hdr_valid), 64'(exp_hv));
      if (m_hdr_valid != '0 && !idle) begin
        chk("hdr_fields", {m_ip_source_ip, m_source_port, m_length},
            {frames[0].ip, frames[0].sp, frames[0].len});
        chk("hdr_dest", 64'(m_dest_port), 64'(frames[0].dp));
      end
      if (idle) exp_str = 1'b0;
      else if (ch < 0) exp_str = 1'b1;
      else if (!hdr_seen) exp_str = 1'b0;
      else exp_str = m_tready[ch];
      exp_tv = (!idle && ch >= 0 && hdr_seen && s_tvalid) ? onehot(ch) : '0;
      chk("s_tready", 64'(s_tready), 64'(exp_str));
      chk("m_tvalid", 64'(m_tvalid), 64'(exp_tv));
      if (!idle && ch >= 0 && !hdr_seen) begin
        if ((m_hdr_valid & m_hdr_ready) != '0) hdr_seen = 1'b1;
      end else if (!idle && ch >= 0 && hdr_seen && s_tvalid && m_tready[ch]) begin
        if (exp_beats.size() == 0) begin
          chk("unexpected_beat", 64'(1), 64'(0));
        end else begin
          bt = exp_beats.pop_front();
          chk("beat", 64'({m_tdata, m_tkeep, m_tlast, m_tuser}), 64'({bt.d, bt.k, bt.l, bt.u}));
          if (bt.l) begin
            void'(frames.pop_front());
            hdr_seen = 1'b0;
          end
        end
      end else if (!idle && ch < 0 && s_tvalid && s_tlast) begin
        void'(frames.pop_front());
      end
    end
  end

  task automatic send_frame(input logic [15:0] dest, input int nbeats, input int pin_ch,
                            input logic [KW-1:0] last_keep, input logic last_user,
                            input int abort_after, input bit scramble);
    int     ch;
    int     t;
    bit     lat_done;
    frame_t f;
    beat_t  bq[$];
    beat_t  bt;
    @(posedge clk);
    #1;
    s_hdr_valid    = 1'b1;
    s_dest_port    = dest;
    s_ip_source_ip = $urandom;
    s_source_port  = 16'($urandom);
    s_length       = 16'(nbeats * KW);
    t = 0;
    forever begin
      @(negedge clk);
      if (s_hdr_ready) break;
      t++;
      if (t > 200) begin
        chk("hdr_accept_timeout", 64'(0), 64'(1));
        s_hdr_valid = 1'b0;
        return;
      end
    end
    ch = model_match(dest);
    if (pin_ch != -2) chk("model_pin", 64'(ch), 64'(pin_ch));
    f.ch = ch; f.ip = s_ip_source_ip; f.sp = s_source_port; f.dp = dest; f.len = s_length;
    for (int b = 0; b < nbeats; b++) begin
      bt.d = $urandom;
      bt.l = (b == nbeats - 1);
      bt.k = bt.l ? last_keep : '1;
      bt.u = bt.l ? last_user : 1'b0;
      bq.push_back(bt);
    end
    @(posedge clk);
    frames.push_back(f);
    if (ch >= 0) begin
      foreach (bq[i]) exp_beats.push_back(bq[i]);
    end else if (exp_drops != 32'hFFFF_FFFF) begin
      exp_drops++;
    end
    $display("frame dest=%0d channel=%0d beats=%0d keep_last=%0h user_last=%0d", dest, ch, nbeats, last_keep, last_user);
    #1;
    s_hdr_valid = 1'b0;
    if (scramble) begin
      port_table  = {$urandom, $urandom};
      port_enable = NP'($urandom);
    end
    lat_done = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (b > 0 && $urandom_range(3) == 0) begin
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_tvalid = 1'b1;
      s_tdata  = bq[b].d;
      s_tkeep  = bq[b].k;
      s_tlast  = bq[b].l;
      s_tuser  = bq[b].u;
      if (b == abort_after) begin
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_m_hdr_valid", 64'(m_hdr_valid), 64'(0));
        chk("rst_s_tready", 64'(s_tready), 64'(0));
        chk("rst_s_hdr_ready", 64'(s_hdr_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_drop_count", 64'(drop_count), 64'(0));
        chk("rst_hdr_fields", {m_ip_source_ip, m_dest_port}, 64'(0));
        frames.delete();
        exp_beats.delete();
        hdr_seen  = 1'b0;
        exp_drops = '0;
        s_tvalid  = 1'b0;
        s_tlast   = 1'b0;
        s_tuser   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        return;
      end
      t = 0;
      forever begin
        @(negedge clk);
        if (!lat_done) begin
          chk("hdr_latency", 64'(m_hdr_valid), 64'(onehot(ch)));
          chk("drop_count", 64'(drop_count), 64'(exp_drops));
          lat_done = 1'b1;
        end
        if (s_tready) break;
        t++;
        if (t > 300) begin
          chk("beat_accept_timeout", 64'(0), 64'(1));
          s_tvalid = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    @(negedge clk);
    chk("busy_after_last", 64'(busy), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual not finished, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int held;
    logic [15:0] pool [6];
    logic [15:0] d;
    pool[0] = 16'd0;    pool[1] = 16'd80;   pool[2] = 16'd5000;
    pool[3] = 16'd6000; pool[4] = 16'd1234; pool[5] = 16'd9;

    // Reset state
    #3;
    chk("reset_s_hdr_ready", 64'(s_hdr_ready), 64'(1));
    chk("reset_s_tready", 64'(s_tready), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_drop_count", 64'(drop_count), 64'(0));
    chk("reset_m_valids", 64'({m_hdr_valid, m_tvalid}), 64'(0));
    chk("reset_fields", {m_ip_source_ip, m_length, m_source_port}, 64'(0));
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Basic routing: dest 6000 to channel 2, three beats
    port_table  = {16'd7000, 16'd6000, 16'd5001, 16'd5000};
    port_enable = 4'b1111;
    send_frame(16'd6000, 3, 2, 4'hF, 1'b0, -1, 1'b0);
    chk("drop_count_after_match", 64'(drop_count), 64'(0));

    // No match: five beats swallowed, counter 0 -> 1
    send_frame(16'd1234, 5, -1, 4'hF, 1'b0, -1, 1'b0);
    chk("drop_count_after_drop", 64'(drop_count), 64'(1));

    // Priority among duplicate entries
    port_table  = {16'd100, 16'd90, 16'd80, 16'd80};
    port_enable = 4'b1110;
    send_frame(16'd80, 2, 1, 4'hF, 1'b0, -1, 1'b0);
    port_enable = 4'b1111;
    send_frame(16'd80, 2, 0, 4'hF, 1'b0, -1, 1'b0);

    // Header stalled on channel 1 while payload waits
    port_table  = {16'd7000, 16'd6000, 16'd5001, 16'd5000};
    hold_hdr1 = 1'b1;
    held = 0;
    fork
      send_frame(16'd5001, 4, 1, 4'hF, 1'b0, -1, 1'b0);
      begin
        repeat (14) begin
          @(negedge clk);
          if (m_hdr_valid == 4'b0010) begin
            held++;
            chk("stall_s_tready", 64'(s_tready), 64'(0));
          end
        end
        chk("stall_cycles_ge_10", 64'(held >= 10), 64'(1));
        hold_hdr1 = 1'b0;
      end
    join

    // Channel 3 with random m_tready and partial keep on the last beat; errored frame passes
    send_frame(16'd7000, 6, 3, 4'b0011, 1'b1, -1, 1'b0);

    // Table changes mid-frame do not affect the frame in flight
    send_frame(16'd5000, 4, 0, 4'b0111, 1'b0, -1, 1'b1);

    // All channels disabled
    port_table  = {16'd7000, 16'd6000, 16'd5001, 16'd5000};
    port_enable = 4'b0000;
    send_frame(16'd5000, 2, -1, 4'hF, 1'b0, -1, 1'b0);

    // Dest 0 is an ordinary value
    port_table  = {16'd0, 16'd6000, 16'd5001, 16'd5000};
    port_enable = 4'b1000;
    send_frame(16'd0, 2, 3, 4'hF, 1'b0, -1, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NP; i++) port_table[16*i +: 16] = pool[$urandom_range(5)];
      port_enable = NP'($urandom);
      d = ($urandom_range(7) == 0) ? 16'($urandom) : pool[$urandom_range(5)];
      send_frame(d, $urandom_range(1, 6), -2, KW'($urandom_range(1, 15)),
                 1'($urandom), -1, 1'($urandom));
    end

    // Reset mid-payload, then a fresh frame to 5000
    port_table  = {16'd7000, 16'd6000, 16'd5001, 16'd5000};
    port_enable = 4'b1111;
    if (drop_count == 0) send_frame(16'd4321, 1, -1, 4'hF, 1'b0, -1, 1'b0);
    send_frame(16'd6000, 6, 2, 4'hF, 1'b0, 2, 1'b0);
    send_frame(16'd5000, 3, 0, 4'hF, 1'b0, -1, 1'b0);
    chk("drop_count_after_reset", 64'(drop_count), 64'(0));

    repeat (3) @(posedge clk);
    chk("frames_drained", 64'(frames.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_port_demux.md
UDP_PORT_DEMUX -- requirements
Module: udp_port_demux

Interface
REQ-001 Parameter N_PORTS, default 4, SHALL set the number of output channels (1..16).
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the payload tdata width in bits (8, 16, 32 or 64); KEEP_WIDTH = DATA_WIDTH/8.
REQ-003 Port list (name, direction, width, meaning):
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- port_table  in  16*N_PORTS  UDP dest port for channel i, at bits [16i+15:16i].
- port_enable  in  N_PORTS  channel i participates in matching when bit i = 1.
- s_hdr_valid / s_hdr_ready  in / out  1 / 1  input UDP header handshake.
- s_ip_source_ip  in  32  header field.
- s_source_port  in  16  header field.
- s_dest_port  in  16  header field.
- s_length  in  16  header field.
- s_tdata / s_tkeep  in  DATA_WIDTH / KEEP_WIDTH  input payload.
- s_tvalid / s_tready / s_tlast / s_tuser  in / out / in / in  1 each  input payload handshake.
- m_hdr_valid / m_hdr_ready  out / in  N_PORTS each  per-channel header handshake.
- m_ip_source_ip, m_source_port, m_dest_port, m_length  out  32/16/16/16  shared header fields for all channels.
- m_tdata / m_tkeep  out  DATA_WIDTH / KEEP_WIDTH  shared payload bus.
- m_tvalid / m_tready  out / in  N_PORTS each  per-channel payload handshake.
- m_tlast, m_tuser  out  1 each  shared payload sideband.
- busy  out  1  high when the FSM is not IDLE.
- drop_count  out  32  frames discarded because no channel matched.

Function
REQ-004 The FSM SHALL have states IDLE, HDR (header presented), FWD (payload forwarding) and DROP.
REQ-005 In IDLE, s_hdr_ready SHALL be 1 and s_tready SHALL be 0.
REQ-006 Outside IDLE, s_hdr_ready SHALL be 0.
REQ-007 Matching: on the s_hdr handshake, the block SHALL select the lowest index i with port_enable[i]=1 and port_table[i]=s_dest_port.
REQ-008 port_table and port_enable SHALL be sampled only at the s_hdr handshake; changes mid-frame SHALL have no effect on the current frame.
REQ-009 On a match, the header fields and index i SHALL be registered and the FSM SHALL enter HDR.
REQ-010 m_hdr_valid[i] SHALL assert in the cycle after the s_hdr handshake (latency 1) and stay asserted, with fields stable, until m_hdr_ready[i]=1.
REQ-011 On the m_hdr handshake, the FSM SHALL enter FWD.
REQ-012 In HDR, s_tready SHALL be 0, so payload is never forwarded before its header.
REQ-013 In FWD, payload SHALL pass through combinationally with zero latency:
- m_tvalid[i] = s_tvalid; s_tready = m_tready[i].
- m_tdata, m_tkeep, m_tlast and m_tuser follow the s_ inputs.
- all m_tvalid[j] for j≠i SHALL be 0.
REQ-014 On a beat with s_tvalid & s_tready & s_tlast, the FWD state SHALL return to IDLE in the next cycle.
REQ-015 A new header SHALL be accepted no earlier than the cycle after a FWD or DROP frame ends.
REQ-016 No match: the FSM SHALL enter DROP and increment drop_count in the cycle after the s_hdr handshake.
REQ-017 drop_count SHALL saturate at 0xFFFFFFFF.
REQ-018 In DROP, s_tready SHALL be 1, all m_tvalid SHALL be 0, and beats SHALL be discarded.
REQ-019 DROP SHALL return to IDLE after the tlast beat.
REQ-020 A frame whose tuser=1 on its last beat SHALL still be forwarded with m_tuser=1; the block SHALL NOT filter errored frames.
REQ-021 Only one channel's m_hdr_valid or m_tvalid SHALL be high at any time; all other bits SHALL be 0.
REQ-022 With every port_enable bit 0, every frame SHALL be dropped.
REQ-023 A header with s_dest_port = 0 SHALL follow the same matching rule as any other value (no special case).

Reset
REQ-024 On reset_n low, asynchronously:
- FSM = IDLE.
- m_hdr_valid = 0 and m_tvalid = 0.
- s_hdr_ready = 1 and s_tready = 0.
- busy = 0 and drop_count = 0.
- registered header fields = 0.
REQ-025 Reset deassertion SHALL be synchronous to clk.
REQ-026 Reset mid-frame SHALL abandon the frame without emitting a partial tlast; upstream is reset in the same domain.

Verification
REQ-027 Table {5000, 5001, 6000, 7000}, enable 4'b1111; header dest 6000 plus 3-beat payload -> m_hdr_valid = 4'b0100 one cycle later; 3 beats on channel 2 with tlast on beat 3; drop_count = 0.
REQ-028 Header dest 1234 (no match) plus 5-beat payload -> s_tready = 1 for all 5 beats; no m_tvalid; drop_count 0 -> 1; busy falls the cycle after tlast.
REQ-029 Table {80, 80, 90, 100}, enable 4'b1110; dest 80 -> routed to channel 1; then enable 4'b1111, dest 80 -> routed to channel 0.
REQ-030 m_hdr_ready[1] held 0 for 10 cycles with s_tvalid = 1 -> s_tready stays 0 and no beat is lost; both handshakes then complete in order.
REQ-031 m_tready[3] toggled randomly during FWD, DATA_WIDTH = 32, tkeep = 4'b0011 on the last beat -> output byte stream and tkeep match the input exactly.
REQ-032 Assert reset_n low in FWD mid-payload -> all m_tvalid = 0 within the same cycle; after release, a new frame to port 5000 is routed correctly.
